// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide engine producing the HI/LO write stream.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a one-cycle product.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             we_hi,
  output logic             we_lo,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StWr} state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;
  logic               r_we_hi;
  logic               r_we_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic               w_div_borrow;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_last;

  always_comb begin
    w_signed = (op == OpMult) || (op == OpDiv);
    w_a_neg  = w_signed & a[WIDTH-1];
    w_b_neg  = w_signed & b[WIDTH-1];
    w_mag_a  = w_a_neg ? -a : a;
    w_mag_b  = w_b_neg ? -b : b;
    w_last   = (r_cnt == CntW'(WIDTH - 1));
  end

  // Shift-add step: low half of r_acc holds the remaining multiplier bits.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd & {WIDTH{r_acc[0]}}};
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_prod     = r_neg_q ? -w_mul_next : w_mul_next;
  end

  // Restoring step: upper half is the partial remainder, lower half shifts dividend into quotient.
  always_comb begin
    w_div_shift  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_diff   = {1'b0, w_div_shift} - {2'b00, r_opnd};
    w_div_borrow = w_div_diff[WIDTH+1];
    w_div_rem    = w_div_borrow ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
    w_div_next   = {w_div_rem, r_acc[WIDTH-2:0], ~w_div_borrow};
    w_quo        = r_neg_q ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
    w_rem        = r_neg_r ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_mag;
  logic [2*WIDTH-1:0] w_fast;

  always_comb begin
    w_fast_mag = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
    w_fast     = (w_a_neg ^ w_b_neg) ? -w_fast_mag : w_fast_mag;
  end
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we_hi <= 1'b0;
      r_we_lo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_we_hi <= 1'b0;
      r_we_lo <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start && !flush) begin
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            case (op)
              OpMult, OpMultu: begin
`ifdef MULDIV_FAST_MUL_EN
                {r_hi, r_lo} <= w_fast;
                r_done       <= 1'b1;
                r_we_hi      <= 1'b1;
                r_we_lo      <= 1'b1;
                r_state      <= StWr;
`else
                r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                r_opnd  <= w_mag_a;
                r_busy  <= 1'b1;
                r_state <= StMul;
`endif
              end
              OpDiv, OpDivu: begin
                if (b == '0) begin
                  r_hi    <= a;
                  r_lo    <= '1;
                  r_done  <= 1'b1;
                  r_we_hi <= 1'b1;
                  r_we_lo <= 1'b1;
                  r_state <= StWr;
                end else begin
                  r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                  r_opnd  <= w_mag_b;
                  r_busy  <= 1'b1;
                  r_state <= StDiv;
                end
              end
              OpMthi: begin
                r_hi    <= a;
                r_done  <= 1'b1;
                r_we_hi <= 1'b1;
                r_state <= StWr;
              end
              OpMtlo: begin
                r_lo    <= a;
                r_done  <= 1'b1;
                r_we_lo <= 1'b1;
                r_state <= StWr;
              end
              default: ;
            endcase
          end
        end
        StMul: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + CntW'(1);
            if (w_last) begin
              {r_hi, r_lo} <= w_prod;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_we_hi      <= 1'b1;
              r_we_lo      <= 1'b1;
              r_state      <= StWr;
            end
          end
        end
        StDiv: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + CntW'(1);
            if (w_last) begin
              r_hi    <= w_rem;
              r_lo    <= w_quo;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_we_hi <= 1'b1;
              r_we_lo <= 1'b1;
              r_state <= StWr;
            end
          end
        end
        StWr: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign we_hi    = r_we_hi;
  assign we_lo    = r_we_lo;
  assign hi_wdata = r_hi;
  assign lo_wdata = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: transaction-level model plus directed vectors.
module tb_muldiv_unit;

  localparam int W       = 32;
  localparam int LatIter = W + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LatMul  = 1;
`else
  localparam int LatMul  = LatIter;
`endif

  logic         clk   = 1'b0;
  logic         clr_n = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, we_hi, we_lo;
  logic [W-1:0] hi_wdata, lo_wdata;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .we_hi    (we_hi),
    .we_lo    (we_lo),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Architectural result of one op, straight from MIPS arithmetic semantics.
  function automatic void compute(input logic [2:0] o, input logic [W-1:0] va, vb,
                                  output logic [W-1:0] rhi, rlo, output logic whi, wlo,
                                  output int lat);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    rhi = '0; rlo = '0; whi = 1'b1; wlo = 1'b1; lat = 1;
    case (o)
      3'd0: begin p = sa * sb; rhi = p[63:32]; rlo = p[31:0]; lat = LatMul; end
      3'd1: begin p = {32'h0, va} * {32'h0, vb}; rhi = p[63:32]; rlo = p[31:0]; lat = LatMul; end
      3'd2, 3'd3: begin
        if (vb == '0) begin
          rhi = va; rlo = '1;
        end else begin
          if (o == 3'd2) begin q = sa / sb; r = sa % sb; end
          else begin q = {32'h0, va} / {32'h0, vb}; r = {32'h0, va} % {32'h0, vb}; end
          rhi = r[31:0]; rlo = q[31:0]; lat = LatIter;
        end
      end
      3'd4: begin rhi = va; wlo = 1'b0; end
      default: begin rlo = va; whi = 1'b0; end
    endcase
  endfunction

  logic         m_busy, m_done, m_whi, m_wlo, p_whi, p_wlo;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  int           m_rem;

  always @(posedge clk or negedge clr_n) begin : model
    logic [W-1:0] t_hi, t_lo;
    logic         t_whi, t_wlo;
    int           t_lat;
    if (!clr_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_whi <= 1'b0; m_wlo <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_rem <= 0;
      p_hi <= '0; p_lo <= '0; p_whi <= 1'b0; p_wlo <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0; m_whi <= 1'b0; m_wlo <= 1'b0;
    end else if (m_rem != 0) begin
      if (flush) begin
        m_rem <= 0; m_busy <= 1'b0;
      end else if (m_rem == 1) begin
        m_rem <= 0; m_busy <= 1'b0; m_done <= 1'b1;
        m_whi <= p_whi; m_wlo <= p_wlo;
        if (p_whi) m_hi <= p_hi;
        if (p_wlo) m_lo <= p_lo;
      end else begin
        m_rem <= m_rem - 1;
      end
    end else if (start && !flush && op < 3'd6) begin
      compute(op, a, b, t_hi, t_lo, t_whi, t_wlo, t_lat);
      if (t_lat == 1) begin
        m_done <= 1'b1; m_whi <= t_whi; m_wlo <= t_wlo;
        if (t_whi) m_hi <= t_hi;
        if (t_wlo) m_lo <= t_lo;
      end else begin
        p_hi <= t_hi; p_lo <= t_lo; p_whi <= t_whi; p_wlo <= t_wlo;
        m_rem <= t_lat - 1; m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model busy", 64'(busy), 64'(m_busy));
      chk("model done", 64'(done), 64'(m_done));
      chk("model we_hi", 64'(we_hi), 64'(m_whi));
      chk("model we_lo", 64'(we_lo), 64'(m_wlo));
      chk("model hi_wdata", 64'(hi_wdata), 64'(m_hi));
      chk("model lo_wdata", 64'(lo_wdata), 64'(m_lo));
    end
  end

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] va, vb,
                        input logic [W-1:0] ehi, elo, input logic ewhi, ewlo, input int elat);
    int cyc;
    int nbusy;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    cyc = 0; nbusy = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      cyc++;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    chk({name, " done seen"}, 64'(seen), 64'd1);
    chk({name, " latency"}, 64'(cyc), 64'(elat));
    chk({name, " busy cycles"}, 64'(nbusy), 64'(elat - 1));
    if (seen) begin
      chk({name, " hi"}, 64'(hi_wdata), 64'(ehi));
      chk({name, " lo"}, 64'(lo_wdata), 64'(elo));
      chk({name, " we_hi"}, 64'(we_hi), 64'(ewhi));
      chk({name, " we_lo"}, 64'(we_lo), 64'(ewlo));
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " busy"}, 64'(busy), 64'd0);
    chk({name, " done"}, 64'(done), 64'd0);
    chk({name, " we_hi"}, 64'(we_hi), 64'd0);
    chk({name, " we_lo"}, 64'(we_lo), 64'd0);
    chk({name, " hi"}, 64'(hi_wdata), 64'd0);
    chk({name, " lo"}, 64'(lo_wdata), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #2 clr_n = 1'b0;
    cmp_en = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk);
    #2 clr_n = 1'b1;

    run_op("multu max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,
           1'b1, 1'b1, LatMul);
    run_op("mult neg", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b1, LatMul);
    run_op("div neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b1, LatIter);
    run_op("divu by zero", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1, 1'b1, 1);
    run_op("mthi", 3'd4, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
    run_op("mtlo", 3'd5, 32'hABCDEF01, 32'h0, 32'h12345678, 32'hABCDEF01, 1'b0, 1'b1, 1);
    run_op("div ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b1, 1'b1, LatIter);

    // Start with flush in idle is dropped; outputs keep the previous write.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'h55;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush idle done", 64'(done), 64'd0);
    chk("flush idle we_hi", 64'(we_hi), 64'd0);
    chk("flush idle hi", 64'(hi_wdata), 64'd0);

    // Reserved opcode is ignored.
    start = 1'b1; op = 3'd6; a = 32'h99;
    @(negedge clk);
    start = 1'b0;
    chk("reserved busy", 64'(busy), 64'd0);
    chk("reserved done", 64'(done), 64'd0);

    run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b1, LatIter);
    run_op("mult minneg", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,
           1'b1, 1'b1, LatMul);
    run_op("mult by m1", 3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001,
           1'b1, 1'b1, LatMul);
    run_op("div negdiv", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b1, 1'b1, LatIter);
    run_op("divu big", 3'd3, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b1, 1'b1, LatIter);
    run_op("multu shift", 3'd1, 32'h12345678, 32'h100, 32'h12, 32'h34567800,
           1'b1, 1'b1, LatMul);

    // Flush at iteration 10 of a divide; a start while busy is ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("flush div busy before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush div busy after", 64'(busy), 64'd0);
    chk("flush div done", 64'(done), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || we_hi || we_lo) seen = 1'b1;
    end
    chk("flush div no write", 64'(seen), 64'd0);
    chk("flush div hi kept", 64'(hi_wdata), 64'h12);

    // Flush during the write cycle does not cancel the write.
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    chk("flush wr done", 64'(done), 64'd1);
    chk("flush wr lo", 64'(lo_wdata), 64'hCAFEF00D);
    @(negedge clk);
    flush = 1'b0;

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 clr_n = 1'b0;
    #1 chk_zero("mid reset");
    @(negedge clk);
    #2 clr_n = 1'b1;

    run_op("after reset", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1, 1'b1, LatMul);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle MIPS multiply/divide engine that produces the HI/LO write stream consumed by the HI/LO register pair.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage.
- Computes iteratively over WIDTH cycles.
- Drives independent HI/LO write enables and data with a one-cycle done pulse so the pipeline can stall on busy.

Parameters:
- WIDTH, 32, operand width and width of each of HI/LO; even, ≥4.

Ports:
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low reset
- start  input  1  op request; sampled on rising edge when busy=0
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=reserved
- a  input  WIDTH  rs operand (multiplicand/dividend/MT source)
- b  input  WIDTH  rt operand (multiplier/divisor)
- flush  input  1  abort in-flight op, no write
- busy  output  1  high while an iterative op is in progress
- done  output  1  one-cycle pulse, coincident with the write
- we_hi  output  1  HI write enable
- we_lo  output  1  LO write enable
- hi_wdata  output  WIDTH  value to write into HI
- lo_wdata  output  WIDTH  value to write into LO

Behaviour:
- Reset: clr_n=0 asynchronously forces state IDLE; busy, done, we_hi, we_lo = 0; hi_wdata, lo_wdata = 0; iteration counter and internal registers = 0.
- States: IDLE, MUL, DIV, WR.
- IDLE
  - start=1, op 0/1 -> MUL: latch operand magnitudes and result sign, counter=0.
  - start=1, op 2/3 with b≠0 -> DIV.
  - start=1, op 2/3 with b=0 -> WR, result HI=a, LO={WIDTH{1}}.
  - start=1, op 4 -> WR, HI=a, only we_hi.
  - start=1, op 5 -> WR, LO=a, only we_lo.
  - op 6/7 -> ignored, stay IDLE.
- MUL: radix-2 shift-add, one bit per cycle. After WIDTH iterations, apply sign (2's-complement negate of the 2*WIDTH product if signs differ, MULT only) -> WR. HI=product[2W-1:W], LO=product[W-1:0].
- DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH iterations -> WR.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (DIV only).
  - HI=remainder, LO=quotient.
  - Overflow case DIV of 0x80000000 (most negative) by -1: LO=0x80000000, HI=0.
- WR: done=1 for exactly one cycle. we_hi/we_lo high per op (both for mul/div); hi_wdata/lo_wdata valid that cycle -> IDLE.
- busy=1 in MUL and DIV only; 0 in IDLE and WR.
- Latency from start edge to done: MUL/DIV = WIDTH+1 cycles; MTHI/MTLO/divide-by-zero = 1 cycle.
- Back-to-back: a start sampled in WR is not accepted. The next start is taken in IDLE, so issue rate is one op per (latency+1) cycles.
- start while busy=1 is ignored; operands are latched, so a/b changes mid-operation have no effect.
- flush=1 in MUL/DIV: next state IDLE, no done, no write enables.
- flush in WR: write still occurs.
- flush in IDLE with start: flush wins, op discarded.
- hi_wdata/lo_wdata hold their last written value outside WR.
- We_hi/we_lo never assert outside WR.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational 2*WIDTH product registered into WR. Latency 1 cycle; busy stays 0 for multiplies. Divide path unchanged.
- Undefined: iterative multiplier as above, WIDTH+1 latency.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 32 cycles; done at cycle 33 with HI=0xFFFFFFFE, LO=0x00000001, we_hi=we_lo=1.
- MULT a=-3 (0xFFFFFFFD) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=-7 b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=7 b=0 -> done after 1 cycle, HI=7, LO=0xFFFFFFFF.
- MTHI a=0x12345678 -> next cycle we_hi=1, we_lo=0, hi_wdata=0x12345678, done=1, busy never high.
- DIV started, flush=1 at iteration 10 -> no done, no we, busy=0 next cycle. A second start while busy is ignored. clr_n=0 mid-MUL -> all outputs 0 immediately.
- DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
